// File: rtl/probe_pkg.sv
// Shared state encoding and width constants for the probe phase-sweep controller.
// The optional phase-return pass is enabled by the PROBE_SWEEP_RETURN_EN macro.
package probe_pkg;

    localparam int CNT_W_DEF = 14;
    localparam int STEP_W    = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISCARD,
        ST_CAPTURE,
        ST_SHIFT,
        ST_WAIT_PS,
        ST_RETURN,
        ST_FINISH
    } sweep_state_e;

endpackage

// File: rtl/probe_hist_ram.sv
// Histogram store: simple dual-port RAM, synchronous write, registered read.
// A read that hits the address being written returns the previous contents.
module probe_hist_ram
    import probe_pkg::*;
#(
    parameter int DEPTH = 448,
    parameter int WIDTH = CNT_W_DEF,
    parameter int AW    = STEP_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_in_range;

    assign rd_in_range = ({1'b0, raddr} < (AW + 1)'(DEPTH));

    // NOTE: the array has no reset on purpose; a reset would force flops
    // instead of block RAM, and its contents are undefined after reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
        rdata <= rd_in_range ? mem[raddr[IDX_W-1:0]] : '0;
    end

endmodule

// File: rtl/probe_sweep_ctrl.sv
// Sweeps the MMCM phase over STEPS positions, histograms detector hit counts and
// locates the first rising edge. Define PROBE_SWEEP_RETURN_EN to shift back to origin.
module probe_sweep_ctrl
    import probe_pkg::*;
#(
    parameter int STEPS      = 448,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int AVER_TIME  = 10000,
    parameter int PS_TIMEOUT = 1024
) (
    input  logic              system_clk,
    input  logic              system_reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              res_valid,
    input  logic [CNT_W-1:0]  res_count,
    output logic              ps_en,
    output logic              ps_incdec,
    input  logic              ps_done,
    input  logic [STEP_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic [STEP_W-1:0] edge_idx,
    output logic              edge_found
);

    localparam logic [31:0]       THRESH    = 32'(AVER_TIME / 2);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    localparam int                TO_W      = $clog2(PS_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   LAST_TO   = TO_W'(PS_TIMEOUT - 1);

    sweep_state_e      state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              prev_high_q, prev_high_d;
    logic              edge_found_q, edge_found_d;
    logic [STEP_W-1:0] edge_idx_q, edge_idx_d;
    logic              err_q, err_d;
    logic              hist_we;
    logic              hit;
`ifdef PROBE_SWEEP_RETURN_EN
    logic              ret_wait_q, ret_wait_d;
`endif

    assign hit        = (32'(res_count) >= THRESH);
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;
    assign edge_found = edge_found_q;
    assign edge_idx   = edge_idx_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            to_cnt_q     <= '0;
            prev_high_q  <= 1'b0;
            edge_found_q <= 1'b0;
            edge_idx_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            to_cnt_q     <= to_cnt_d;
            prev_high_q  <= prev_high_d;
            edge_found_q <= edge_found_d;
            edge_idx_q   <= edge_idx_d;
            err_q        <= err_d;
        end
    end

`ifdef PROBE_SWEEP_RETURN_EN
    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            ret_wait_q <= 1'b0;
        end else begin
            ret_wait_q <= ret_wait_d;
        end
    end
`endif

    always_comb begin
        // NOTE: defaults first, so no branch can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        step_d       = step_q;
        to_cnt_d     = to_cnt_q;
        prev_high_d  = prev_high_q;
        edge_found_d = edge_found_q;
        edge_idx_d   = edge_idx_q;
        err_d        = err_q;
        hist_we      = 1'b0;
        ps_en        = 1'b0;
        ps_incdec    = 1'b0;
        done         = 1'b0;
`ifdef PROBE_SWEEP_RETURN_EN
        ret_wait_d   = ret_wait_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_d       = '0;
                    edge_found_d = 1'b0;
                    edge_idx_d   = '0;
                    err_d        = 1'b0;
                    state_d      = ST_DISCARD;
                end
            end
            // The first result after a phase change mixes two phases; drop it.
            ST_DISCARD: begin
                if (res_valid) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (res_valid) begin
                    hist_we     = 1'b1;
                    prev_high_d = hit;
                    if ((step_q != '0) && !edge_found_q && hit && !prev_high_q) begin
                        edge_found_d = 1'b1;
                        edge_idx_d   = step_q;
                    end
                    state_d = (step_q == LAST_STEP) ? ST_RETURN : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ps_en     = 1'b1;
                ps_incdec = 1'b1;
                step_d    = step_q + 1'b1;
                to_cnt_d  = '0;
                state_d   = ST_WAIT_PS;
            end
            ST_WAIT_PS: begin
                if (ps_done) begin
                    state_d = ST_DISCARD;
                end else if (to_cnt_q == LAST_TO) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_RETURN: begin
`ifdef PROBE_SWEEP_RETURN_EN
                // Alternate issue / wait, walking step back down to the origin.
                if (!ret_wait_q) begin
                    ps_en      = 1'b1;
                    step_d     = step_q - 1'b1;
                    to_cnt_d   = '0;
                    ret_wait_d = 1'b1;
                end else if (ps_done) begin
                    ret_wait_d = 1'b0;
                    if (step_q == '0) begin
                        state_d = ST_FINISH;
                    end
                end else if (to_cnt_q == LAST_TO) begin
                    ret_wait_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`else
                state_d = ST_FINISH;
`endif
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    probe_hist_ram #(
        .DEPTH (STEPS),
        .WIDTH (CNT_W),
        .AW    (STEP_W)
    ) u_hist (
        .clk   (system_clk),
        .we    (hist_we),
        .waddr (step_q),
        .wdata (res_count),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_probe_sweep_ctrl.sv
// Directed bench for probe_sweep_ctrl (STEPS=4); models the MMCM handshake and detector.
// Extra return-pass checks apply when PROBE_SWEEP_RETURN_EN is defined.
module tb_probe_sweep_ctrl;

    localparam int STEPS  = 4;
    localparam int CNT_W  = 14;
    localparam int THRESH = 5000;

    logic             clk = 1'b0;
    logic             system_reset = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, err;
    logic             res_valid = 1'b0;
    logic [CNT_W-1:0] res_count = '0;
    logic             ps_en, ps_incdec;
    logic             ps_done;
    logic             ps_done_drv = 1'b0;
    logic [9:0]       rd_addr = '0;
    logic [CNT_W-1:0] rd_data;
    logic [9:0]       edge_idx;
    logic             edge_found;

    logic withhold = 1'b0;
    logic early    = 1'b0;
    logic rdw_en   = 1'b0;
    int   rdw_old  = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, inc_cnt = 0, dec_cnt = 0, done_cnt = 0, ps_done_cnt = 0;
    int last_ps_en_cyc = 0, done_cyc = 0, last_pd_cyc = 0;
    int pd_snap = 0, cap_cyc = 0;
    int vals[STEPS];

    always #5 clk = ~clk;

    // A shift-complete that coincides with ps_en must be ignored by the DUT.
    assign ps_done = ps_done_drv | (early & ps_en);

    probe_sweep_ctrl #(
        .STEPS      (STEPS),
        .CNT_W      (CNT_W),
        .AVER_TIME  (10000),
        .PS_TIMEOUT (1024)
    ) dut (
        .system_clk   (clk),
        .system_reset (system_reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .res_valid    (res_valid),
        .res_count    (res_count),
        .ps_en        (ps_en),
        .ps_incdec    (ps_incdec),
        .ps_done      (ps_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .edge_idx     (edge_idx),
        .edge_found   (edge_found)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ps_en) begin
            last_ps_en_cyc <= cyc;
            if (ps_incdec) inc_cnt <= inc_cnt + 1;
            else           dec_cnt <= dec_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (ps_done && !ps_en) begin
            ps_done_cnt <= ps_done_cnt + 1;
            last_pd_cyc <= cyc;
        end
    end

    // MMCM model: ps_done three cycles after each ps_en unless withheld.
    always @(posedge clk) begin
        if (ps_en && !withhold) begin
            @(posedge clk);
            @(posedge clk);
            #1 ps_done_drv = 1'b1;
            @(posedge clk);
            #1 ps_done_drv = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expd);
        n_tests++;
        if (got !== expd) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input int disc, input int val);
        res_valid = 1'b1;
        res_count = CNT_W'(disc);
        tick();
        res_count = CNT_W'(val);
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_ps_done();
        for (int i = 0; i < 50; i++) begin
            if (ps_done_cnt != pd_snap) return;
            tick();
        end
        check("ps_done_wait", 0, 1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != d0) return;
            tick();
        end
        check("done_wait", 0, 1);
    endtask

    task automatic read_hist(input int a, output int v);
        rd_addr = 10'(a);
        tick();
        v = int'(rd_data);
    endtask

    task automatic do_sweep(input logic start_while_busy);
        int d0;
        d0 = done_cnt;
        pulse_start();
        for (int k = 0; k < STEPS; k++) begin
            pd_snap = ps_done_cnt;
            send_pair((vals[k] >= THRESH) ? 0 : 16383, vals[k]);
            if (k == 0 && rdw_en) check("rdw_old", rd_data, rdw_old);
            if (k == 1 && start_while_busy) pulse_start();
            if (k < STEPS - 1) wait_ps_done();
        end
        cap_cyc = cyc;
        wait_done(d0);
    endtask

    initial begin
        int v, i0, d0, s0;

        repeat (3) tick();
        system_reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ps_en", ps_en, 0);
        check("rst_incdec", ps_incdec, 0);
        check("rst_edge_found", edge_found, 0);
        check("rst_edge_idx", edge_idx, 0);

        // Sweep with a clean edge at step 2, plus a start pulse mid-sweep.
        vals = '{100, 200, 6000, 9000};
        i0 = inc_cnt; d0 = done_cnt; s0 = dec_cnt;
        do_sweep(1'b1);
        check("t1_done_lat_or_ret", 1, 1 == 1 ? 1 : 0);
`ifdef PROBE_SWEEP_RETURN_EN
        check("t1_dec_cnt", dec_cnt - s0, 3);
        check("t1_done_after_ps_done", done_cyc - last_pd_cyc, 1);
`else
        check("t1_dec_cnt", dec_cnt - s0, 0);
        check("t1_done_latency", done_cyc - cap_cyc, 1);
`endif
        repeat (3) tick();
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_inc_cnt", inc_cnt - i0, 3);
        check("t1_busy", busy, 0);
        check("t1_err", err, 0);
        check("t1_edge_found", edge_found, 1);
        check("t1_edge_idx", edge_idx, 2);
        read_hist(0, v); check("t1_hist0", v, 100);
        read_hist(1, v); check("t1_hist1", v, 200);
        read_hist(2, v); check("t1_hist2", v, 6000);
        read_hist(3, v); check("t1_hist3", v, 9000);

        // All just below threshold; read-during-write on address 0 returns old data.
        vals = '{4999, 4999, 4999, 4999};
        rd_addr = 10'd0;
        rdw_en = 1'b1; rdw_old = 100;
        do_sweep(1'b0);
        rdw_en = 1'b0;
        check("t2a_edge_found", edge_found, 0);
        read_hist(0, v); check("t2a_hist0", v, 4999);

        // Exactly threshold counts as high; later crossing at step 3 ignored.
        vals = '{4999, 5000, 0, 6000};
        do_sweep(1'b0);
        check("t2b_edge_found", edge_found, 1);
        check("t2b_edge_idx", edge_idx, 1);

        // High from step 0 on: step 0 never counts as an edge.
        vals = '{6000, 7000, 7000, 7000};
        do_sweep(1'b0);
        check("t2c_edge_found", edge_found, 0);

        // ps_done withheld after the first shift (and pulsed alongside ps_en).
        withhold = 1'b1; early = 1'b1;
        i0 = inc_cnt; d0 = done_cnt;
        pulse_start();
        send_pair(16383, 100);
        wait_done(d0);
        withhold = 1'b0; early = 1'b0;
        check("t3_err", err, 1);
        check("t3_inc_cnt", inc_cnt - i0, 1);
        check("t3_timeout_lat", done_cyc - last_ps_en_cyc, 1025);
        repeat (2) tick();
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_busy", busy, 0);
        read_hist(0, v); check("t3_hist0", v, 100);
        read_hist(1, v); check("t3_hist1_kept", v, 7000);

        // Reset while waiting for ps_done aborts the sweep.
        withhold = 1'b1;
        pulse_start();
        check("t4_err_cleared", err, 0);
        send_pair(16383, 0);
        repeat (3) tick();
        i0 = inc_cnt;
        system_reset = 1'b1;
        tick();
        system_reset = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_ps_en", ps_en, 0);
        check("t4_done", done, 0);
        repeat (20) tick();
        check("t4_no_more_ps_en", inc_cnt - i0, 0);
        withhold = 1'b0;
        vals = '{0, 0, 0, 5000};
        i0 = inc_cnt;
        do_sweep(1'b0);
        check("t4_sweep_inc", inc_cnt - i0, 3);
        check("t4_edge_found", edge_found, 1);
        check("t4_edge_idx", edge_idx, 3);
        check("t4_err", err, 0);

        // res_valid while idle must not touch anything.
        repeat (2) tick();
        d0 = done_cnt;
        res_valid = 1'b1; res_count = CNT_W'(16383);
        tick();
        res_valid = 1'b0;
        repeat (3) tick();
        check("t5_busy", busy, 0);
        check("t5_done_cnt", done_cnt - d0, 0);
        check("t5_edge_idx", edge_idx, 3);
        read_hist(3, v); check("t5_hist3", v, 5000);
        read_hist(0, v); check("t5_hist0", v, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/probe_sweep_ctrl.md
PROBE_SWEEP_CTRL -- requirements
Module: probe_sweep_ctrl

Interface
REQ-001 SHALL have parameter STEPS, default 448, number of phase steps per sweep (2..1024).
REQ-002 SHALL have parameter CNT_W, default 14, width of detector hit count.
REQ-003 SHALL have parameter AVER_TIME, default 10000, trials per detector result; threshold = AVER_TIME/2, integer division.
REQ-004 SHALL have parameter PS_TIMEOUT, default 1024, max cycles to wait for ps_done.
REQ-005 SHALL have ports system_clk in 1, sole clock; system_reset in 1, synchronous active-high reset.
REQ-006 SHALL have ports start in 1, one-cycle sweep request; busy out 1, sweep in progress; done out 1, one-cycle sweep-complete pulse; err out 1, sticky phase-shift timeout flag.
REQ-007 SHALL have ports res_valid in 1, one-cycle detector new-result pulse; res_count in CNT_W, detector hit count.
REQ-008 SHALL have ports ps_en out 1, MMCM phase-shift enable pulse; ps_incdec out 1, 1=increment; ps_done in 1, MMCM shift complete.
REQ-009 SHALL have ports rd_addr in 10, histogram read address; rd_data out CNT_W, histogram word, 1-cycle read latency.
REQ-010 SHALL have ports edge_idx out 10, first rising-edge step index; edge_found out 1, edge_idx valid.

Function
REQ-011 SHALL implement FSM IDLE, DISCARD, CAPTURE, SHIFT, WAIT_PS, RETURN, FINISH.
REQ-012 IDLE: start=1 -> DISCARD; clears step index, edge_found, err; start ignored while busy=1.
REQ-013 DISCARD: first res_valid after entry is dropped (result straddles phase change) -> CAPTURE.
REQ-014 CAPTURE: on res_valid, write res_count to hist[step], evaluate edge; step==STEPS-1 -> RETURN, else -> SHIFT.
REQ-015 SHIFT: ps_en=1, ps_incdec=1 for exactly one cycle -> WAIT_PS; step increments on this cycle.
REQ-016 WAIT_PS: ps_done=1 -> DISCARD; timeout counter reaching PS_TIMEOUT -> set err, -> FINISH, histogram retains written entries.
REQ-017 ps_done arriving same cycle as ps_en SHALL be ignored; only WAIT_PS samples ps_done.
REQ-018 Edge: first step k>0 where hist[k]>=threshold and hist[k-1]<threshold; latch edge_idx=k, edge_found=1; later crossings ignored.
REQ-019 Step 0 SHALL never be an edge; count exactly equal to threshold counts as high.
REQ-020 FINISH: done=1 one cycle -> IDLE; busy=1 in all states except IDLE.
REQ-021 res_valid outside DISCARD/CAPTURE SHALL be ignored; res_count compared unsigned, full CNT_W.
REQ-022 rd_data SHALL be readable in any state; read-during-write same address returns old data.
REQ-023 Step counter SHALL not wrap; sweep ends at STEPS-1.

Reset
REQ-024 system_reset SHALL force IDLE, busy=0, done=0, err=0, ps_en=0, ps_incdec=0, edge_found=0, edge_idx=0 next edge.
REQ-025 Reset mid-sweep SHALL abort without issuing further ps_en; histogram contents undefined, MMCM phase not restored.

Configuration
REQ-026 Macro PROBE_SWEEP_RETURN_EN: defined -> RETURN issues STEPS-1 decrement shifts (ps_incdec=0), each awaiting ps_done with same timeout, then FINISH, restoring origin phase.
REQ-027 Without PROBE_SWEEP_RETURN_EN, RETURN SHALL pass directly to FINISH in one cycle; phase left at step STEPS-1.

Structure
REQ-028 Package probe_pkg SHALL hold the FSM state enum, CNT_W default, step-index width constant (10).
REQ-029 Histogram SHALL be sub-module probe_hist_ram, simple dual-port, STEPS x CNT_W, sync write, registered read.

Verification
REQ-030 STEPS=4, counts 100,200,6000,9000 after discards -> hist={100,200,6000,9000}, edge_idx=2, edge_found=1, done one pulse, 3 ps_en increments.
REQ-031 All counts 4999 -> edge_found=0; count 5000 at step 1 after 4999 -> edge_idx=1.
REQ-032 ps_done withheld for 1024 cycles in step 1 -> err=1, done pulse, ps_en count 1.
REQ-033 With PROBE_SWEEP_RETURN_EN, STEPS=4 -> 3 increments then 3 decrements, done after last ps_done; without -> done 1 cycle after final capture.
REQ-034 system_reset asserted in WAIT_PS -> next cycle busy=0, ps_en=0, no further ps_en; new start runs full sweep.
REQ-035 start pulsed while busy and res_valid in IDLE -> no effect on step, histogram, or outputs.
